// File: rtl/seg7_display_driver.sv
// Signed 13-bit value to 8-digit common-anode seven-segment display.
// Sequential double-dabble conversion, leading-zero blanking, 5-slot scan.
module seg7_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [12:0] value_in,
  output logic [7:0]         an,
  output logic [6:0]         seg,
  output logic               dp,
  output logic               busy
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic signed [12:0] shown_val;
  logic signed [12:0] conv_val;
  logic [12:0]        mag;
  logic [15:0]        bcd;
  logic [15:0]        bcd_adj;
  logic [3:0]         cnt;
  logic [3:0]         d0, d1, d2, d3;
  logic               neg;
  logic [12:0]        mag_in;

  logic [RW-1:0]      refresh_cnt;
  logic               refresh_wrap;
  logic [2:0]         scan_idx;
  logic [2:0]         scan_next;
  logic [2:0]         nsig;
  logic [3:0]         cur_digit;
  logic [6:0]         pos_seg;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = 7'b1111111;
    endcase
  endfunction

  // Magnitude in 13 unsigned bits, so -4096 maps to 4096 without overflow.
  always_comb begin
    mag_in = $unsigned(value_in);
    if (value_in[12]) mag_in = ~$unsigned(value_in) + 13'd1;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shown_val <= '0;
      conv_val  <= '0;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      d0        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      neg       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value_in != shown_val) begin
            conv_val <= value_in;
            mag      <= mag_in;
            bcd      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj[14:0], mag, 1'b0};
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd12) state <= DONE;
        end
        DONE: begin
          d0        <= bcd[3:0];
          d1        <= bcd[7:4];
          d2        <= bcd[11:8];
          d3        <= bcd[15:12];
          neg       <= conv_val[12];
          shown_val <= conv_val;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));

  // Outputs are registered against the next scan slot so an/seg change together.
  always_comb begin
    scan_next = scan_idx;
    if (refresh_wrap) scan_next = (scan_idx == 3'd4) ? 3'd0 : scan_idx + 3'd1;

    if (d3 != 4'd0)      nsig = 3'd4;
    else if (d2 != 4'd0) nsig = 3'd3;
    else if (d1 != 4'd0) nsig = 3'd2;
    else                 nsig = 3'd1;

    case (scan_next)
      3'd0:    cur_digit = d0;
      3'd1:    cur_digit = d1;
      3'd2:    cur_digit = d2;
      3'd3:    cur_digit = d3;
      default: cur_digit = 4'd0;
    endcase

    if (scan_next < nsig)             pos_seg = digit_seg(cur_digit);
    else if (scan_next == nsig && neg) pos_seg = 7'b0111111;
    else                               pos_seg = 7'b1111111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      an          <= 8'hFE;
      seg         <= 7'b1000000;
      dp          <= 1'b1;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
      scan_idx    <= scan_next;
      an          <= ~(8'b1 << scan_next);
      seg         <= pos_seg;
      dp          <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Bench for seg7_display_driver: decimal-arithmetic reference model checked
// every cycle, plus literal display expectations for directed cases.
module tb_seg7_display_driver;

  localparam int R = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [12:0] value_in = '0;
  logic [7:0]         an;
  logic [6:0]         seg;
  logic               dp;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_display_driver #(.REFRESH_DIV(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .value_in (value_in),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy)
  );

  logic [6:0] dig_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  int pw [4] = '{1, 10, 100, 1000};

  function automatic logic [6:0] pos_pat(input int v, input int p);
    int a, nd;
    a  = (v < 0) ? -v : v;
    nd = (a >= 1000) ? 4 : (a >= 100) ? 3 : (a >= 10) ? 2 : 1;
    if (p < nd)               return dig_tab[(a / pw[p]) % 10];
    else if (p == nd && v < 0) return 7'b0111111;
    else                       return 7'b1111111;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: shown value changes 14 edges after the capture edge; scan slot
  // after edge n is floor(n/R) mod 5.
  int         n_e, shown_m, conv_m, cd, pm;
  logic       busy_e;
  logic [7:0] an_e;
  logic [6:0] seg_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_e = 0; shown_m = 0; conv_m = 0; cd = 0; busy_e = 1'b0;
      an_e = 8'hFE; seg_e = 7'b1000000;
    end else begin
      n_e++;
      pm    = (n_e / R) % 5;
      an_e  = ~(8'b1 << pm);
      seg_e = pos_pat(shown_m, pm);
      if (cd == 0) begin
        if (int'(value_in) != shown_m) begin
          conv_m = int'(value_in); cd = 14; busy_e = 1'b1;
        end
      end else begin
        cd--;
        if (cd == 0) begin shown_m = conv_m; busy_e = 1'b0; end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_an",   32'(an),   32'(an_e));
      chk("model_seg",  32'(seg),  32'(seg_e));
      chk("model_dp",   32'(dp),   32'd1);
      chk("model_busy", 32'(busy), 32'(busy_e));
    end
  end

  task automatic lit_pos(input int p, input logic [6:0] exp, input string nm);
    bit found = 0;
    logic [7:0] want;
    want = ~(8'b1 << p);
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (an == want) found = 1;
    end
    if (!found) chk({nm, "_slot_timeout"}, 32'(an), 32'(want));
    else        chk(nm, 32'(seg), 32'(exp));
  endtask

  task automatic set_val(input int v);
    @(negedge clk);
    value_in = 13'(v);
  endtask

  task automatic reset_literals(input string nm);
    chk({nm, "_an"},   32'(an),   32'hFE);
    chk({nm, "_seg"},  32'(seg),  32'b1000000);
    chk({nm, "_dp"},   32'(dp),   32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int blen, v;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset between edges
    @(posedge clk); #2 rst = 1'b1;
    #1 reset_literals("async_rst");
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1234: busy length and all five slots
    set_val(1234);
    blen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) blen++;
      else if (blen > 0) break;
    end
    chk("busy_len_1234", 32'(blen), 32'd14);
    repeat (2) @(negedge clk);
    lit_pos(0, 7'b0011001, "p0_1234");
    lit_pos(1, 7'b0110000, "p1_1234");
    lit_pos(2, 7'b0100100, "p2_1234");
    lit_pos(3, 7'b1111001, "p3_1234");
    lit_pos(4, 7'b1111111, "p4_1234");

    set_val(-4096);
    repeat (17) @(negedge clk);
    lit_pos(0, 7'b0000010, "p0_m4096");
    lit_pos(1, 7'b0010000, "p1_m4096");
    lit_pos(2, 7'b1000000, "p2_m4096");
    lit_pos(3, 7'b0011001, "p3_m4096");
    lit_pos(4, 7'b0111111, "p4_m4096");

    set_val(-7);
    repeat (17) @(negedge clk);
    lit_pos(0, 7'b1111000, "p0_m7");
    lit_pos(1, 7'b0111111, "p1_m7");
    lit_pos(2, 7'b1111111, "p2_m7");
    lit_pos(3, 7'b1111111, "p3_m7");
    lit_pos(4, 7'b1111111, "p4_m7");

    // Change while converting: 100 shown first, then 99
    set_val(100);
    repeat (5) @(posedge clk);
    @(negedge clk) value_in = 13'sd99;
    repeat (12) @(negedge clk);
    lit_pos(2, 7'b1111001, "p2_100_first");
    repeat (16) @(negedge clk);
    lit_pos(0, 7'b0010000, "p0_99");
    lit_pos(1, 7'b0010000, "p1_99");
    lit_pos(2, 7'b1111111, "p2_99");

    // Reset in the middle of converting 4095
    set_val(4095);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_literals("midconv_rst");
    @(negedge clk) rst = 1'b0;
    repeat (17) @(negedge clk);
    lit_pos(0, 7'b0010010, "p0_4095");
    lit_pos(1, 7'b0010000, "p1_4095");
    lit_pos(2, 7'b1000000, "p2_4095");
    lit_pos(3, 7'b0011001, "p3_4095");

    set_val(0);
    repeat (20) @(negedge clk);

    // Random values with random hold times, including short holds
    for (int i = 0; i < 60; i++) begin
      v = int'($urandom_range(0, 8191)) - 4096;
      if (i % 10 == 3) v = 0;
      set_val(v);
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
